add16_reg: RTL and testbench
============================

// Module: add16_reg
// PURPOSE
//   16-bit binary adder with registered result, used as the ALU add path.
//   Computes out = a + b modulo 2^16 (carry discarded from out, exported
//   separately). Built from a gate-level ripple-carry chain; the result is
//   captured in output registers one clock after the operands are presented.
// PARAMETERS
//   WIDTH    16   operand/result width in bits; all tests run at 16
// PORTS
//   clk        in   1      system clock, rising-edge active
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a/b hold a valid operand pair this cycle
//   a          in   WIDTH  operand A, unsigned or two's complement
//   b          in   WIDTH  operand B, unsigned or two's complement
//   out        out  WIDTH  registered sum, (a+b) mod 2^WIDTH
//   carry_out  out  1      registered carry out of the MSB
//   out_valid  out  1      out/carry_out hold the result of a valid pair
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low (clk, rst_n).
//   - rst_n low: out=0, carry_out=0, out_valid=0 immediately, no clock
//     needed. Deassertion is released on a clk edge. Reset mid-operation
//     discards any in-flight result.
//   - Latency: exactly 1 cycle. Operands sampled at edge N appear on
//     out/carry_out after edge N. out_valid after edge N = in_valid at N.
//   - Throughput: one operation per cycle, no stall, no backpressure.
//   - in_valid=0: out and carry_out still load the sum of the current a/b
//     (free-running datapath). Only out_valid qualifies the result.
//   - Arithmetic: sum = a + b with carry-in 0. out = sum[WIDTH-1:0].
//     carry_out = sum[WIDTH]. No overflow flag, no saturation.
//     Wrap-around is the required behaviour: FFFF+FFFF -> FFFE, carry 1.
//     0000+FFFF -> FFFF, carry 0.
//   - The signed/unsigned interpretation of the operands does not change
//     the result bits.
//   - No X-propagation allowances: after reset every output is a known value.
// STRUCTURE
//   - Shared package adder_pkg: localparam ADD_WIDTH = 16.
//   - Sub-module full_adder: (a, b, cin) -> (sum, cout).
//     sum = a^b^cin. cout = (a&b)|(cin&(a^b)).
//   - add16_reg contains a generate loop of WIDTH full_adder instances in a
//     ripple chain, with cin[0]=0. It also holds the output register block.
//   - No behavioural '+' in the datapath. The bench is the golden model and
//     uses '+'.
// TESTING
//   - Reset: rst_n=0 with no clock edge -> out=0000, carry_out=0,
//     out_valid=0. Release reset, drive in_valid=0 -> out_valid stays 0.
//   - Vectors, in_valid=1, each checked one cycle later:
//     0000+0000 -> 0000, carry 0.
//     0000+FFFF -> FFFF, carry 0.
//     FFFF+FFFF -> FFFE, carry 1.
//     AAAA+5555 -> FFFF, carry 0.
//     3CC3+0FF0 -> 4CB3, carry 0.
//     1234+9876 -> AAAA, carry 0.
//   - Back-to-back: apply the six vectors on consecutive cycles -> six
//     consecutive correct results, out_valid high throughout.
//   - Carry ripple: 0001+FFFF -> 0000, carry 1. 7FFF+0001 -> 8000, carry 0.
//   - Async reset mid-stream: pull rst_n low between clock edges -> outputs
//     clear at once. Next valid pair after release -> correct result.
//   - Random: 10k random pairs versus the {carry,out} = a+b model, latency 1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
package adder_pkg;
    localparam int ADD_WIDTH = 16;
endpackage

// File: rtl/add16_reg_if.sv
// Operand/result bundle for add16_reg; master drives operands, slave returns the sum.
interface add16_reg_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    logic             out_valid;

    modport master (
        output in_valid, a, b,
        input  out, carry_out, out_valid
    );

    modport slave (
        input  in_valid, a, b,
        output out, carry_out, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// One-bit gate-level full adder cell for the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic half;

    assign half = a ^ b;
    assign sum  = half ^ cin;
    assign cout = (a & b) | (cin & half);
endmodule

// File: rtl/add16_reg.sv
// Ripple-carry adder with a one-cycle output register; the datapath runs every
// cycle and only out_valid says whether the registered sum belongs to a real pair.
module add16_reg
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input logic       clk,
    input logic       rst_n,
    add16_reg_if.slave bus
);
    logic [WIDTH:0]   carry_p0;
    logic [WIDTH-1:0] sum_p0;

    logic [WIDTH-1:0] sum_p1;
    logic             carry_p1;
    logic             vld_p1;

    assign carry_p0[0] = 1'b0;

    // Stage 0: combinational ripple chain, LSB first
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .cin  (carry_p0[i]),
            .sum  (sum_p0[i]),
            .cout (carry_p0[i+1])
        );
    end

    // Stage 1: output registers, cleared asynchronously so no X ever leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1   <= '0;
            carry_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            sum_p1   <= sum_p0;
            carry_p1 <= carry_p0[WIDTH];
            vld_p1   <= bus.in_valid;
        end
    end

    assign bus.out       = sum_p1;
    assign bus.carry_out = carry_p1;
    assign bus.out_valid = vld_p1;
endmodule

// File: tb/tb_add16_reg.sv
// Scoreboard bench for add16_reg: stimulus pushes {carry,sum} expectations, a
// negedge monitor pops and compares whenever out_valid is high.
module tb_add16_reg;
    import adder_pkg::*;

    localparam int W = ADD_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    add16_reg_if #(.WIDTH(W)) bus ();

    add16_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [W:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Hold operands for one rising edge; returns at posedge+1.
    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic v,
                         input logic [W:0] exp);
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = v;
        if (v) exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: got out=%h carry=%b with empty scoreboard",
                         bus.out, bus.carry_out);
            end else begin
                check("result", {15'b0, bus.carry_out, bus.out}, {15'b0, exp_q.pop_front()});
            end
        end
    end

    logic [W-1:0] va [6] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234};
    logic [W-1:0] vb [6] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h5555, 16'h0FF0, 16'h9876};
    logic [W:0]   vr [6] = '{17'h00000, 17'h0FFFF, 17'h1FFFE, 17'h0FFFF, 17'h04CB3, 17'h0AAAA};

    initial begin
        logic [W-1:0] ra, rb;
        logic         rv;

        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;

        // Reset asserted before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_out", {16'b0, bus.out}, 32'h0);
        check("rst_carry", {31'b0, bus.carry_out}, 32'h0);
        check("rst_valid", {31'b0, bus.out_valid}, 32'h0);

        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // in_valid low: no valid, but datapath still loads the sum
        apply(16'h0001, 16'h0002, 1'b0, '0);
        check("idle_valid", {31'b0, bus.out_valid}, 32'h0);
        check("idle_free_run", {15'b0, bus.carry_out, bus.out}, 32'h00003);

        for (int i = 0; i < 6; i++) begin
            apply(va[i], vb[i], 1'b1, vr[i]);
            apply('0, '0, 1'b0, '0);
        end

        for (int i = 0; i < 6; i++) apply(va[i], vb[i], 1'b1, vr[i]);

        apply(16'h0001, 16'hFFFF, 1'b1, 17'h10000);
        apply(16'h7FFF, 16'h0001, 1'b1, 17'h08000);
        apply('0, '0, 1'b0, '0);

        // Async reset between edges while a valid result is being held
        apply(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out", {16'b0, bus.out}, 32'h0);
        check("midrst_carry", {31'b0, bus.carry_out}, 32'h0);
        check("midrst_valid", {31'b0, bus.out_valid}, 32'h0);
        exp_q.delete();
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply(16'h1234, 16'h9876, 1'b1, 17'h0AAAA);
        apply('0, '0, 1'b0, '0);

        for (int i = 0; i < 10000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rv = ($urandom_range(0, 9) != 0);
            apply(ra, rb, rv, {1'b0, ra} + {1'b0, rb});
        end

        repeat (3) apply('0, '0, 1'b0, '0);
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
